err_stats_acc: RTL and testbench
================================

Name: err_stats_acc

Overview:
- Parametrised windowed error-statistics accumulator for the receiver's error-measurement chain, the successor to the fixed-width DC error accumulator.
- Integrates exactly 2^LOG2_WIN enabled error samples per window, in one of two modes: DC mean or mean-square.
- Window counting, first/last tagging, one-shot or continuous operation, and result latching are internal; no external hold strobe is needed.
- Feeds software-readable MER/DC-offset statistics.

Parameters:
- DATA_W, 18, signed error sample width (1sDATA_W-1 format).
- LOG2_WIN, 10, window length is 2^LOG2_WIN enabled samples (bench uses 4).
- ACC_W, 2*DATA_W-1+LOG2_WIN, accumulator width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_en  in  1  sample strobe; err is valid when high.
- start  in  1  single-cycle request to begin (or restart) a window.
- clear  in  1  synchronous abort; returns to idle.
- mode  in  1  0 = DC mean, 1 = mean-square; latched on accepted start.
- cont  in  1  1 = auto-restart the next window seamlessly; latched on accepted start.
- err  in  DATA_W  signed error sample.
- mean_out  out  DATA_W  latched window result; signed in mode 0, unsigned in mode 1.
- acc_out_full  out  ACC_W  latched full window sum (signed mode 0, unsigned mode 1).
- done  out  1  one-cycle pulse when mean_out/acc_out_full update.
- busy  out  1  high while a window is in progress.
- sample_cnt  out  LOG2_WIN  samples accepted in the current window.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs, accumulator, counter and pipeline registers are 0.
- FSM IDLE:
  - start -> RUN; zero counter; latch mode and cont; flag the next sample first.
  - clk_en samples are ignored in IDLE.
- FSM RUN:
  - Each clk_en cycle captures one sample into stage 1: sign-extended err (mode 0) or err*err (mode 1, unsigned 2*DATA_W-1 bits).
  - The captured sample is tagged first when sample_cnt==0 and last when sample_cnt==2^LOG2_WIN-1.
  - sample_cnt increments and wraps to 0 after last.
- Stage 2 (accumulator), one clock after capture:
  - acc <= (first ? 0 : acc) + stage1.
  - When last: register mean_out and acc_out_full from the new sum in the same edge, and pulse done in the following cycle.
- Latency: last sample presented with clk_en at edge T; results valid and done high after edge T+1.
- Window end with cont=0: RUN -> IDLE at edge T, busy falls. The in-flight last sample still completes.
- Window end with cont=1: stay in RUN. The next clk_en sample is first of the new window; no sample is dropped, even with clk_en high every cycle.
- Result extraction:
  - Mode 0: mean_out = acc[ACC_W-1... sign-extended sum]>>>LOG2_WIN, truncated to DATA_W (arithmetic shift, floor toward -inf). The sum fits in DATA_W+LOG2_WIN signed bits; upper accumulator bits are sign extension.
  - Mode 1: mean_out = sum >> (LOG2_WIN+DATA_W-1), unsigned. Max value 2^(DATA_W-1) for full-scale negative input.
- No overflow is possible: ACC_W covers 2^LOG2_WIN worst-case squares.
- Outputs hold their last latched values until the next window completes or reset.
- Priority: reset > clear > start > window-end.
  - clear: -> IDLE, counter and pipeline flags zeroed, no done; outputs retained.
  - start in RUN: restarts the window; counter to 0; the in-flight stage-1 sample is discarded (not accumulated, no done); mode/cont re-latched.
  - start and clear in the same cycle: clear wins.
- mode/cont changes outside an accepted start are ignored until the next start.

Test Plan:
- DC constant (LOG2_WIN=4): start mode0 cont0; 16 samples err=+100 with clk_en every cycle -> acc_out_full=1600, mean_out=100, single done 2 edges after the last capture, busy low after.
- DC floor: 8 samples of -3 then 8 of -2 -> acc_out_full=-40, mean_out=-3 (floor of -2.5).
- Mean-square: mode1, 16 samples err=-131072 -> acc_out_full=2^38, mean_out=131072. Repeat with err=65536 -> mean_out=32768.
- Continuous, clk_en every 4th cycle: 16 samples of +10 then 16 of -10 -> two done pulses, mean_out 10 then -10, sample_cnt wraps 15->0. Same again with clk_en every cycle -> identical results.
- Abort: clear after 7 samples -> busy=0, no done, mean_out keeps prior value. Restart with 16 samples of 5 -> mean_out=5 (no residue from the aborted window).
- Reset mid-window: pull reset low asynchronously mid-cycle -> all outputs 0 immediately. After release, clk_en samples without start are ignored, sample_cnt stays 0.

Source files
------------

// File: rtl/err_stats_acc.sv
// Windowed error-statistics accumulator: integrates 2^LOG2_WIN enabled samples as either
// a DC mean or a mean-square, with one-shot or seamless continuous windows.
module err_stats_acc #(
    parameter int DATA_W   = 18,
    parameter int LOG2_WIN = 10,
    parameter int ACC_W    = 2*DATA_W-1+LOG2_WIN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     mode,
    input  logic                     cont,
    input  logic signed [DATA_W-1:0] err,
    output logic        [DATA_W-1:0] mean_out,
    output logic        [ACC_W-1:0]  acc_out_full,
    output logic                     done,
    output logic                     busy,
    output logic      [LOG2_WIN-1:0] sample_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic             mode_q;
    logic             cont_q;
    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;
    logic             s1_mode;
    logic [ACC_W-1:0] s1_data;
    logic [ACC_W-1:0] acc;

    logic                       accept;
    logic                       last_cnt;
    logic                       acc_en;
    logic signed [2*DATA_W-1:0] sq_full;
    logic [ACC_W-1:0]           s1_next;
    logic [ACC_W-1:0]           acc_sum;
    logic [DATA_W-1:0]          mean_next;

    always_comb begin
        accept   = (state == ST_RUN) && clk_en && !start && !clear;
        last_cnt = (sample_cnt == '1);
        // A restart in RUN or an abort throws away whatever sits in stage 1.
        acc_en   = s1_valid && !clear && !(start && (state == ST_RUN));
        // The square is never negative, so its MSB is always zero.
        sq_full  = err * err;
        s1_next  = mode_q ? ACC_W'($unsigned(sq_full)) : ACC_W'(err);
        acc_sum  = (s1_first ? '0 : acc) + s1_data;
        mean_next = s1_mode ? DATA_W'(acc_sum >> (LOG2_WIN + DATA_W - 1))
                            : DATA_W'($signed(acc_sum) >>> LOG2_WIN);
    end

    assign busy = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            mode_q       <= 1'b0;
            cont_q       <= 1'b0;
            sample_cnt   <= '0;
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            s1_mode      <= 1'b0;
            s1_data      <= '0;
            acc          <= '0;
            mean_out     <= '0;
            acc_out_full <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (acc_en) begin
                acc <= acc_sum;
                if (s1_last) begin
                    acc_out_full <= acc_sum;
                    mean_out     <= mean_next;
                    done         <= 1'b1;
                end
            end

            s1_valid <= accept;
            s1_first <= accept && (sample_cnt == '0);
            s1_last  <= accept && last_cnt;
            if (accept) begin
                s1_data <= s1_next;
                s1_mode <= mode_q;
            end

            if (clear) begin
                state      <= ST_IDLE;
                sample_cnt <= '0;
            end else if (start) begin
                state      <= ST_RUN;
                sample_cnt <= '0;
                mode_q     <= mode;
                cont_q     <= cont;
            end else if (accept) begin
                sample_cnt <= sample_cnt + 1'b1;
                if (last_cnt && !cont_q) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_err_stats_acc.sv
// Scoreboard bench for err_stats_acc with a 16-sample window.
module tb_err_stats_acc;

    localparam int DATA_W   = 18;
    localparam int LOG2_WIN = 4;
    localparam int ACC_W    = 2*DATA_W-1+LOG2_WIN;
    localparam int WIN      = 1 << LOG2_WIN;

    logic                     clk;
    logic                     reset;
    logic                     clk_en;
    logic                     start;
    logic                     clear;
    logic                     mode;
    logic                     cont;
    logic signed [DATA_W-1:0] err;
    logic        [DATA_W-1:0] mean_out;
    logic        [ACC_W-1:0]  acc_out_full;
    logic                     done;
    logic                     busy;
    logic      [LOG2_WIN-1:0] sample_cnt;

    err_stats_acc #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .start        (start),
        .clear        (clear),
        .mode         (mode),
        .cont         (cont),
        .err          (err),
        .mean_out     (mean_out),
        .acc_out_full (acc_out_full),
        .done         (done),
        .busy         (busy),
        .sample_cnt   (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic   m;
        longint sum;
        longint mean;
    } exp_t;

    exp_t   sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint last_mean = 0;

    // Bench-side window model
    logic   m_mode = 1'b0;
    logic   m_cont = 1'b0;
    logic   m_busy = 1'b0;
    int     m_cnt  = 0;
    longint m_sum  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", longint'(done), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.m) begin
                    check("acc_sq", longint'(acc_out_full), e.sum);
                    check("mean_sq", longint'(mean_out), e.mean);
                end else begin
                    check("acc_dc", longint'($signed(acc_out_full)), e.sum);
                    check("mean_dc", longint'($signed(mean_out)), e.mean);
                end
                last_mean = e.mean;
            end
        end
    end

    task automatic do_start(input logic m, input logic c);
        start = 1'b1;
        mode  = m;
        cont  = c;
        @(posedge clk);
        #1;
        start  = 1'b0;
        m_mode = m;
        m_cont = c;
        m_busy = 1'b1;
        m_cnt  = 0;
        check("start_busy", longint'(busy), 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
        check("clear_busy", longint'(busy), 0);
    endtask

    task automatic send(input int v, input int gap);
        exp_t e;
        clk_en = 1'b1;
        err    = DATA_W'(v);
        if (m_busy) begin
            if (m_cnt == 0) m_sum = 0;
            m_sum += m_mode ? longint'(v) * longint'(v) : longint'(v);
            m_cnt = (m_cnt + 1) % WIN;
            if (m_cnt == 0) begin
                e.m    = m_mode;
                e.sum  = m_sum;
                e.mean = m_mode ? (m_sum >> (LOG2_WIN + DATA_W - 1)) : (m_sum >>> LOG2_WIN);
                sb_q.push_back(e);
                if (!m_cont) m_busy = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        check("sample_cnt", longint'(sample_cnt), longint'(m_cnt));
        check("busy", longint'(busy), longint'(m_busy));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, longint'(sb_q.size()), 0);
    endtask

    initial begin
        reset  = 1'b0;
        clk_en = 1'b0;
        start  = 1'b0;
        clear  = 1'b0;
        mode   = 1'b0;
        cont   = 1'b0;
        err    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_mean", longint'(mean_out), 0);
        check("rst_acc", longint'(acc_out_full), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_cnt", longint'(sample_cnt), 0);

        // DC constant, with explicit latency of the done pulse
        do_start(1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) send(100, 0);
        @(negedge clk);
        check("lat_pre_done", longint'(done), 0);
        check("lat_busy_low", longint'(busy), 0);
        @(negedge clk);
        check("lat_done", longint'(done), 1);
        @(negedge clk);
        check("done_one_shot", longint'(done), 0);
        drain("drain_dc");
        @(posedge clk);
        #1;

        // DC floor toward -inf
        do_start(1'b0, 1'b0);
        for (int i = 0; i < WIN / 2; i++) send(-3, 0);
        for (int i = 0; i < WIN / 2; i++) send(-2, 0);
        drain("drain_floor");

        // Mean-square at full-scale negative and half scale
        do_start(1'b1, 1'b0);
        for (int i = 0; i < WIN; i++) send(-131072, 1);
        drain("drain_sq1");
        do_start(1'b1, 1'b0);
        for (int i = 0; i < WIN; i++) send(65536, 0);
        drain("drain_sq2");

        // Continuous, sparse then dense strobes
        do_start(1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) send(10, 3);
        for (int i = 0; i < WIN; i++) send(-10, 3);
        drain("drain_cont_sparse");
        do_start(1'b0, 1'b1);
        for (int i = 0; i < WIN; i++) send(10, 0);
        for (int i = 0; i < WIN; i++) send(-10, 0);
        repeat (3) @(posedge clk);
        #1;
        drain("drain_cont_dense");
        do_clear();

        // Restart mid-window drops the partial window and its in-flight sample
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(50, 0);
        do_start(1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) send(7, 0);
        drain("drain_restart");

        // Abort keeps previous result and leaves no residue
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(9, 0);
        do_clear();
        repeat (4) @(posedge clk);
        #1;
        check("abort_hold", longint'($signed(mean_out)), last_mean);
        do_start(1'b0, 1'b0);
        for (int i = 0; i < WIN; i++) send(5, 0);
        drain("drain_after_abort");
        check("after_abort_mean", longint'($signed(mean_out)), 5);

        // Asynchronous reset mid-window
        do_start(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(1000, 0);
        #3;
        reset = 1'b0;
        m_busy = 1'b0;
        m_cnt  = 0;
        #1;
        check("arst_mean", longint'(mean_out), 0);
        check("arst_acc", longint'(acc_out_full), 0);
        check("arst_done", longint'(done), 0);
        check("arst_busy", longint'(busy), 0);
        check("arst_cnt", longint'(sample_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) send(123, 0);
        check("idle_ignore_cnt", longint'(sample_cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_result", longint'(acc_out_full), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
